// File: rtl/rs_encode_pkg.sv
// Shared Reed-Solomon code constants. Encoder and decoder paths both size
// their datapaths from these.
package rs_encode_pkg;

    localparam int RS_K         = 223;
    localparam int RS_N         = 255;
    localparam int RS_WORD_W    = 8;
    localparam int RS_PAR_BYTES = RS_N - RS_K;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rs_decode_line_demux_datap.sv
// Datapath for the line demux: line/parity shift registers, byte/line
// counters, the destination unit pointer and the end-of-segment flags.
module rs_decode_line_demux_datap
    import rs_encode_pkg::*;
#(
    parameter int DATA_W       = 256,
    parameter int DATA_BYTES   = DATA_W / 8,
    parameter int NUM_LINES    = 7,
    parameter int PARITY_W     = 256,
    parameter int NUM_RS_UNITS = 4,
    parameter int BCNT_W       = 6,
    parameter int LCNT_W       = 3,
    parameter int US_W         = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_line,
    input  logic                 adv_data,
    input  logic                 adv_parity,
    input  logic [DATA_W-1:0]    src_decoder_line,
    input  logic [PARITY_W-1:0]  src_decoder_parity,
    output logic [RS_WORD_W-1:0] data_byte,
    output logic [RS_WORD_W-1:0] parity_byte,
    output logic [US_W-1:0]      unit_sel,
    output logic                 last_line,
    output logic                 last_data_byte,
    output logic                 last_parity_byte
);

    localparam int LAST_LINE_BYTES = (RS_K % DATA_BYTES == 0) ? DATA_BYTES : (RS_K % DATA_BYTES);

    logic [DATA_W-1:0]   line_reg;
    logic [PARITY_W-1:0] parity_reg;
    logic [BCNT_W-1:0]   byte_cnt;
    logic [LCNT_W-1:0]   line_cnt;

    // Both registers shift left as bytes leave, so the outgoing byte is
    // always the top slice and stays put while the consumer stalls.
    assign data_byte   = line_reg[DATA_W-1 -: RS_WORD_W];
    assign parity_byte = parity_reg[PARITY_W-1 -: RS_WORD_W];

    assign last_line        = (line_cnt == LCNT_W'(NUM_LINES - 1));
    assign last_data_byte   = (byte_cnt == (last_line ? BCNT_W'(LAST_LINE_BYTES - 1)
                                                      : BCNT_W'(DATA_BYTES - 1)));
    assign last_parity_byte = (byte_cnt == BCNT_W'(RS_PAR_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            line_reg   <= '0;
            parity_reg <= '0;
            byte_cnt   <= '0;
            line_cnt   <= '0;
            unit_sel   <= '0;
        end else begin
            if (load_line) begin
                line_reg <= src_decoder_line;
                byte_cnt <= '0;
                if (last_line)
                    parity_reg <= src_decoder_parity;
            end
            if (adv_data) begin
                line_reg <= line_reg << RS_WORD_W;
                if (last_data_byte) begin
                    byte_cnt <= '0;
                    if (!last_line)
                        line_cnt <= line_cnt + 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
            if (adv_parity) begin
                parity_reg <= parity_reg << RS_WORD_W;
                if (last_parity_byte) begin
                    byte_cnt <= '0;
                    line_cnt <= '0;
                    unit_sel <= (unit_sel == US_W'(NUM_RS_UNITS - 1)) ? '0 : unit_sel + 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rs_decode_line_demux_wrap.sv
// Splits wide data lines into a byte stream (data then parity) and steers
// each codeword round-robin to one of several RS decoder units.
module rs_decode_line_demux_wrap
    import rs_encode_pkg::*;
#(
    parameter int DATA_W       = -1,
    parameter int DATA_BYTES   = DATA_W / 8,
    parameter int NUM_LINES    = -1,
    parameter int PARITY_W     = -1,
    parameter int NUM_RS_UNITS = -1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    src_decoder_line_val,
    input  logic [DATA_W-1:0]       src_decoder_line,
    input  logic [PARITY_W-1:0]     src_decoder_parity,
    output logic                    decoder_src_line_rdy,
    output logic [NUM_RS_UNITS-1:0] decoder_dst_byte_vals,
    output logic [RS_WORD_W-1:0]    decoder_dst_byte,
    output logic                    decoder_dst_byte_last,
    input  logic [NUM_RS_UNITS-1:0] dst_decoder_byte_rdys
);

    localparam int BCNT_W = $clog2(max2(DATA_BYTES, RS_PAR_BYTES) + 1);
    localparam int LCNT_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int US_W   = (NUM_RS_UNITS > 1) ? $clog2(NUM_RS_UNITS) : 1;

    localparam logic [1:0] ST_READY       = 2'd0;
    localparam logic [1:0] ST_SEND_DATA   = 2'd1;
    localparam logic [1:0] ST_SEND_PARITY = 2'd2;

    logic [1:0]           state;
    logic [RS_WORD_W-1:0] data_byte, parity_byte;
    logic [US_W-1:0]      unit_sel;
    logic                 last_line, last_data_byte, last_parity_byte;
    logic                 busy, fire, accept;

    assign busy   = (state != ST_READY);
    assign fire   = busy && dst_decoder_byte_rdys[unit_sel];
    assign accept = (state == ST_READY) && src_decoder_line_val;

    rs_decode_line_demux_datap #(
        .DATA_W       (DATA_W),
        .DATA_BYTES   (DATA_BYTES),
        .NUM_LINES    (NUM_LINES),
        .PARITY_W     (PARITY_W),
        .NUM_RS_UNITS (NUM_RS_UNITS),
        .BCNT_W       (BCNT_W),
        .LCNT_W       (LCNT_W),
        .US_W         (US_W)
    ) u_datap (
        .clk                (clk),
        .rst                (rst),
        .load_line          (accept),
        .adv_data           (fire && (state == ST_SEND_DATA)),
        .adv_parity         (fire && (state == ST_SEND_PARITY)),
        .src_decoder_line   (src_decoder_line),
        .src_decoder_parity (src_decoder_parity),
        .data_byte          (data_byte),
        .parity_byte        (parity_byte),
        .unit_sel           (unit_sel),
        .last_line          (last_line),
        .last_data_byte     (last_data_byte),
        .last_parity_byte   (last_parity_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_READY;
        end else begin
            case (state)
                ST_READY:
                    if (src_decoder_line_val)
                        state <= ST_SEND_DATA;
                ST_SEND_DATA:
                    if (fire && last_data_byte)
                        state <= last_line ? ST_SEND_PARITY : ST_READY;
                ST_SEND_PARITY:
                    if (fire && last_parity_byte)
                        state <= ST_READY;
                default:
                    state <= ST_READY;
            endcase
        end
    end

    // Handshake outputs are gated by rst so they drop in the reset cycle itself.
    always_comb begin
        decoder_dst_byte_vals = '0;
        for (int i = 0; i < NUM_RS_UNITS; i++)
            decoder_dst_byte_vals[i] = !rst && busy && (unit_sel == US_W'(i));
    end

    assign decoder_src_line_rdy  = !rst && (state == ST_READY);
    assign decoder_dst_byte      = (state == ST_SEND_PARITY) ? parity_byte : data_byte;
    assign decoder_dst_byte_last = !rst && (state == ST_SEND_PARITY) && last_parity_byte;

endmodule

// File: tb/tb_rs_decode_line_demux_wrap.sv
// Randomized scoreboard bench: a codeword-level model queues the expected
// (unit, byte, last) stream and a monitor pops it on every accepted byte.
module tb_rs_decode_line_demux_wrap;

    localparam int DATA_W   = 256;
    localparam int PARITY_W = 256;
    localparam int NLINES   = 7;
    localparam int NU       = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              line_val = 1'b0;
    logic [DATA_W-1:0] line = '0;
    logic [PARITY_W-1:0] parity = '0;
    logic              line_rdy;
    logic [NU-1:0]     vals;
    logic [7:0]        dbyte;
    logic              dlast;
    logic [NU-1:0]     rdys = '1;

    always #5 clk = ~clk;

    rs_decode_line_demux_wrap #(
        .DATA_W(DATA_W), .NUM_LINES(NLINES), .PARITY_W(PARITY_W), .NUM_RS_UNITS(NU)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .src_decoder_line_val  (line_val),
        .src_decoder_line      (line),
        .src_decoder_parity    (parity),
        .decoder_src_line_rdy  (line_rdy),
        .decoder_dst_byte_vals (vals),
        .decoder_dst_byte      (dbyte),
        .decoder_dst_byte_last (dlast),
        .dst_decoder_byte_rdys (rdys)
    );

    typedef struct {
        int       unit;
        logic [7:0] b;
        bit       last;
    } exp_t;

    exp_t q[$];
    int   acc_marks[$];
    int   tests = 0, fails = 0;
    int   pop_cnt = 0, acc_cnt = 0;
    int   recv[NU];
    int   mode = 0;
    int   exp_unit = 0;
    logic [DATA_W-1:0]   blk_lines[NLINES];
    logic [PARITY_W-1:0] blk_par;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // Consumer-side ready patterns, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (mode)
            0: rdys = '1;
            1: rdys = rdys[0] ? 4'b0000 : 4'b1111;
            2: rdys = 4'($urandom());
            default: rdys = 4'b0010;
        endcase
    end

    // Monitor: pops one expected byte per transfer, checks hold-while-stalled.
    bit         have_prev = 0, exp_first = 0;
    logic [7:0] prev_b;
    logic       prev_last;
    logic [NU-1:0] prev_vals;
    always @(negedge clk) begin
        if (rst) begin
            have_prev = 0;
            exp_first = 0;
        end else begin
            if (exp_first) check("first_byte_next_cycle", 64'(vals != 0), 64'd1);
            exp_first = 0;
            if (vals != 0) begin
                int sel;
                sel = 0;
                for (int i = 0; i < NU; i++) if (vals[i]) sel = i;
                check("vals_onehot", 64'($countones(vals)), 64'd1);
                check("line_rdy_low_busy", 64'(line_rdy), 64'd0);
                if (have_prev) check("stall_hold", {52'd0, prev_vals, prev_b, 3'd0, prev_last},
                                     {52'd0, vals, dbyte, 3'd0, dlast});
                if (rdys[sel]) begin
                    exp_t e;
                    if (q.size() == 0) begin
                        check("unexpected_byte", {32'(sel), 24'd0, dbyte}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        check("byte_stream", {32'(sel), 15'd0, dlast, 8'd0, dbyte},
                              {32'(e.unit), 15'd0, e.last, 8'd0, e.b});
                    end
                    pop_cnt++;
                    recv[sel]++;
                    if (dlast) acc_marks.push_back(acc_cnt);
                    have_prev = 0;
                end else begin
                    have_prev = 1;
                    prev_b = dbyte; prev_last = dlast; prev_vals = vals;
                end
            end else begin
                have_prev = 0;
                check("last_idle", 64'(dlast), 64'd0);
            end
            if (line_val && line_rdy) begin
                acc_cnt++;
                exp_first = 1;
            end
        end
    end

    task automatic gen_block();
        for (int l = 0; l < NLINES; l++) blk_lines[l] = rnd256();
        blk_par = rnd256();
    endtask

    // Queue the bytes a line must produce, then offer it until accepted.
    task automatic send_line(input int l, input bit keep);
        exp_t e;
        int   n, guard;
        n = (l == NLINES - 1) ? 223 - 32 * (NLINES - 1) : 32;
        for (int j = 0; j < n; j++) begin
            e.unit = exp_unit; e.b = 8'(blk_lines[l] >> (8 * (31 - j))); e.last = 0;
            q.push_back(e);
        end
        if (l == NLINES - 1) begin
            for (int j = 0; j < 32; j++) begin
                e.unit = exp_unit; e.b = 8'(blk_par >> (8 * (31 - j))); e.last = (j == 31);
                q.push_back(e);
            end
            exp_unit = (exp_unit + 1) % NU;
        end
        line_val = 1'b1;
        line     = blk_lines[l];
        parity   = (l == NLINES - 1) ? blk_par : rnd256();
        guard    = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!line_rdy && guard < 3000);
        if (!line_rdy) check("line_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        if (!keep) line_val = 1'b0;
    endtask

    task automatic send_block(input bit keep);
        gen_block();
        for (int l = 0; l < NLINES; l++) send_line(l, keep);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q.size() != 0 || vals != 0) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base, r0, guard, acc0;
        for (int i = 0; i < NU; i++) recv[i] = 0;

        // Reset behaviour.
        repeat (3) @(negedge clk);
        check("rst_vals", 64'(vals), 64'd0);
        check("rst_last", 64'(dlast), 64'd0);
        check("rst_line_rdy", 64'(line_rdy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_line_rdy", 64'(line_rdy), 64'd1);
        check("post_rst_vals", 64'(vals), 64'd0);
        @(posedge clk); #1;

        // Single block, all readies high.
        send_block(0);
        drain();
        check("blk1_unit0_bytes", 64'(recv[0]), 64'd255);
        check("blk1_other_units", 64'(recv[1] + recv[2] + recv[3]), 64'd0);

        // Seven more back to back: two blocks per unit in total.
        for (int b = 0; b < 7; b++) send_block(0);
        drain();
        for (int i = 0; i < NU; i++) check("per_unit_510", 64'(recv[i]), 64'd510);

        // Toggling ready (unit 0 again).
        mode = 1;
        send_block(0);
        drain();

        // Random ready pattern for units 1..3.
        mode = 2;
        for (int b = 0; b < 3; b++) send_block(0);
        drain();

        // Only a non-selected unit ready while unit 0 is selected: no progress.
        mode = 3;
        repeat (2) @(posedge clk);
        #1;
        gen_block();
        send_line(0, 0);
        base = pop_cnt;
        repeat (40) @(negedge clk);
        check("stall_no_progress", 64'(pop_cnt - base), 64'd0);
        check("stall_vals_unit0", 64'(vals), 64'd1);
        check("stall_byte0", 64'(dbyte), 64'(8'(blk_lines[0] >> 248)));
        @(posedge clk); #1;
        mode = 0;
        for (int l = 1; l < NLINES; l++) send_line(l, 0);
        drain();

        // Reset around byte 100 of a unit-1 block.
        gen_block();
        base = pop_cnt;
        for (int l = 0; l < 4; l++) send_line(l, 0);
        guard = 0;
        while (pop_cnt - base < 100 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("reached_byte100", 64'(pop_cnt - base >= 100), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        exp_unit = 0;
        @(negedge clk);
        check("midrst_vals", 64'(vals), 64'd0);
        check("midrst_last", 64'(dlast), 64'd0);
        check("midrst_line_rdy", 64'(line_rdy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_release_rdy", 64'(line_rdy), 64'd1);
        @(posedge clk); #1;
        r0 = recv[0];
        mode = 2;
        send_block(0);
        drain();
        check("after_rst_unit0", 64'(recv[0] - r0), 64'd255);

        // Line valid held high across two blocks.
        mode = 0;
        repeat (2) @(posedge clk);
        #1;
        acc_marks.delete();
        acc0 = acc_cnt;
        send_block(1);
        send_block(1);
        line_val = 1'b0;
        drain();
        check("cont_marks", 64'(acc_marks.size()), 64'd2);
        if (acc_marks.size() == 2) begin
            check("cont_acc_blk1", 64'(acc_marks[0] - acc0), 64'd7);
            check("cont_acc_blk2", 64'(acc_marks[1] - acc0), 64'd14);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rs_decode_line_demux_wrap.md
RS_DECODE_LINE_DEMUX_WRAP -- requirements
Module: rs_decode_line_demux_wrap

Interface
REQ-001 SHALL have parameter DATA_W, default -1, line width in bits (multiple of 8).
REQ-002 SHALL have parameter DATA_BYTES, default DATA_W/8, bytes per line.
REQ-003 SHALL have parameter NUM_LINES, default -1, lines per block, equal to ceil(RS_K/DATA_BYTES).
REQ-004 SHALL have parameter PARITY_W, default -1, parity width, equal to (RS_N-RS_K)*RS_WORD_W.
REQ-005 SHALL have parameter NUM_RS_UNITS, default -1, number of downstream RS decoder units.
REQ-006 SHALL have port clk, input, 1 bit, the single clock.
REQ-007 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-008 SHALL have port src_decoder_line_val, input, 1 bit, line valid.
REQ-009 SHALL have port src_decoder_line, input, DATA_W bits, data line.
REQ-010 SHALL have port src_decoder_parity, input, PARITY_W bits, parity; sampled only with the last line of a block.
REQ-011 SHALL have port decoder_src_line_rdy, output, 1 bit, line ready.
REQ-012 SHALL have port decoder_dst_byte_vals, output, NUM_RS_UNITS bits, per-unit byte valid.
REQ-013 SHALL have port decoder_dst_byte, output, RS_WORD_W bits, byte shared by all units.
REQ-014 SHALL have port decoder_dst_byte_last, output, 1 bit, marks the final (RS_N-th) byte of a codeword.
REQ-015 SHALL have port dst_decoder_byte_rdys, input, NUM_RS_UNITS bits, per-unit byte ready.

Function
REQ-016 SHALL implement an FSM with states READY, SEND_DATA, SEND_PARITY.
- READY: decoder_src_line_rdy=1.
- On val&rdy, the line is captured, and parity too if it is the last line; the FSM then goes to SEND_DATA.
REQ-017 SHALL keep decoder_src_line_rdy=0 in SEND_DATA and SEND_PARITY; no line is accepted while bytes are pending.
REQ-018 SHALL, in SEND_DATA, present bytes MSB-first: byte j = line[DATA_W-1-8j -: 8].
- Non-last lines send DATA_BYTES bytes.
- The last line sends LAST_LINE_BYTES = (RS_K%DATA_BYTES==0 ? DATA_BYTES : RS_K%DATA_BYTES); its remaining bytes are discarded.
REQ-019 SHALL return to READY after the final byte of a non-last line, and go to SEND_PARITY after the final data byte of the last line.
REQ-020 SHALL, in SEND_PARITY, send RS_N-RS_K parity bytes MSB-first, then return to READY.
REQ-021 SHALL assert decoder_dst_byte_last only with parity byte RS_N-RS_K-1, i.e. codeword byte RS_N-1.
REQ-022 SHALL drive only decoder_dst_byte_vals[unit_sel], and only in SEND_DATA/SEND_PARITY; all other bits are 0.
REQ-023 SHALL advance a byte only when dst_decoder_byte_rdys[unit_sel]=1; readies of non-selected units are ignored.
REQ-024 SHALL hold decoder_dst_byte and decoder_dst_byte_last stable while a valid byte is stalled.
REQ-025 SHALL produce the first byte of a line in the cycle after line acceptance; throughput is 1 byte/cycle with no bubbles inside a line.
REQ-026 SHALL increment unit_sel after the last byte of each block, wrapping from NUM_RS_UNITS-1 to 0; with NUM_RS_UNITS=1, unit_sel stays 0.
REQ-027 SHALL count lines 0..NUM_LINES-1, wrapping to 0 at block end.
REQ-028 SHALL size byte counters to $clog2(max(DATA_BYTES, RS_N-RS_K)+1).
REQ-029 SHALL ignore src_decoder_line_val outside READY, and ignore src_decoder_parity on non-last lines.

Reset
REQ-030 SHALL, while rst=1, drive all decoder_dst_byte_vals=0, decoder_dst_byte_last=0 and decoder_src_line_rdy=0.
REQ-031 SHALL, on the first cycle after rst deasserts, be in state READY with unit_sel=0, line count=0 and byte count=0, and drive decoder_src_line_rdy=1.
REQ-032 SHALL, on reset mid-block, discard the partial codeword; the next block goes to unit 0.

Structure
REQ-033 SHALL take RS_K, RS_N and RS_WORD_W from the shared rs_encode_pkg; no local redefinition.
REQ-034 SHALL split into the FSM plus one sub-module, rs_decode_line_demux_datap, which holds the line/parity registers, byte/line counters, unit_sel, and the last-byte/last-line flags.

Verification
Common config: RS_K=223, RS_N=255, DATA_W=256, NUM_LINES=7, LAST_LINE_BYTES=31, PARITY_W=256, NUM_RS_UNITS=4.
REQ-035 SHALL cover: 1 block, all readies=1 -> unit 0 receives 255 bytes in line order; bytes 224..255 equal the parity MSB-first; last=1 only on byte 255; the 32nd byte of line 6 is never sent.
REQ-036 SHALL cover: 8 back-to-back blocks -> blocks go to units 0,1,2,3,0,1,2,3; each unit receives exactly 510 bytes.
REQ-037 SHALL cover: dst_decoder_byte_rdys[0] toggling 1,0,1,0 -> each byte held stable while stalled; the received stream is identical to scenario 1.
REQ-038 SHALL cover: only dst_decoder_byte_rdys[1]=1 while unit_sel=0 -> byte 0 held indefinitely, no progress.
REQ-039 SHALL cover: rst pulsed at byte 100 of block 2 (unit 1) -> next cycle all vals=0; after release line_rdy=1 and the next block goes to unit 0.
REQ-040 SHALL cover: src_decoder_line_val=1 held continuously -> exactly 7 line acceptances per 255 bytes; line_rdy=0 throughout byte output.
